// File: rtl/buffer_shift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : buffer_shift_sequencer_pkg
// Description : Step codes shared by the buffer shift sequencer and the
//               shift register it drives.
// Revision    : 1.0
// ============================================================================
package buffer_shift_sequencer_pkg;

    localparam int MUXCONTROL = 4;

    localparam logic [MUXCONTROL-1:0] ST_PAD_INIT_1   = 4'd0;
    localparam logic [MUXCONTROL-1:0] ST_PAD_INIT_2   = 4'd1;
    localparam logic [MUXCONTROL-1:0] ST_PAD_UINIT_1  = 4'd2;
    localparam logic [MUXCONTROL-1:0] ST_PAD_UINIT_2  = 4'd3;
    localparam logic [MUXCONTROL-1:0] ST_UPAD_INIT_1  = 4'd4;
    localparam logic [MUXCONTROL-1:0] ST_UPAD_INIT_2  = 4'd5;
    localparam logic [MUXCONTROL-1:0] ST_UPAD_UINIT_1 = 4'd6;
    localparam logic [MUXCONTROL-1:0] ST_UPAD_UINIT_2 = 4'd7;
    localparam logic [MUXCONTROL-1:0] ST_PAD_END_3    = 4'd8;
    localparam logic [MUXCONTROL-1:0] ST_PAD_END_4    = 4'd9;
    localparam logic [MUXCONTROL-1:0] ST_IDLE         = 4'd15;

    // UPAD codes sit exactly 4 above their PAD counterparts.
    function automatic logic [MUXCONTROL-1:0] step_code(
        input logic pad,
        input logic k_zero,
        input logic k_one,
        input logic k_odd
    );
        logic [1:0] w_off;
        w_off = 2'd2;
        if (k_zero)
            w_off = 2'd0;
        else if (k_one)
            w_off = 2'd1;
        else if (k_odd)
            w_off = 2'd3;
        return {1'b0, ~pad, w_off};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module      : seq_delay_pipe
// Description : DEPTH x WIDTH register pipe with asynchronous reset value.
// Revision    : 1.0
// ============================================================================
module seq_delay_pipe #(
    parameter int             DEPTH   = 2,
    parameter int             WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        r_stage[gi] <= RST_VAL;
                    else
                        r_stage[gi] <= din;
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        r_stage[gi] <= RST_VAL;
                    else
                        r_stage[gi] <= r_stage[gi-1];
                end
            end
        end
    endgenerate

    assign dout = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/buffer_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : buffer_shift_sequencer
// Description : Reads line-buffer words and emits time-aligned step codes,
//               buffermux and iszero for the buffer shift register.
// Revision    : 1.0
// ============================================================================
module buffer_shift_sequencer
    import buffer_shift_sequencer_pkg::*;
#(
    parameter int X_MAC     = 4,
    parameter int X_MESH    = 16,
    parameter int DATA_LEN  = 32,
    parameter int DATAWIDTH = X_MAC * X_MESH * DATA_LEN,
    parameter int ADDR_W    = 10,
    parameter int LEN_W     = 8,
    parameter int LINE_W    = 8,
    parameter int RD_LAT    = 2,
    parameter int DOUT_LAT  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  cfg_pad,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic [LINE_W-1:0]     cfg_lines,
    input  logic [ADDR_W-1:0]     cfg_base,
    input  logic [ADDR_W-1:0]     cfg_stride,
    input  logic [X_MAC*2-1:0]    cfg_buffermux,
    input  logic [X_MAC-1:0]      cfg_zero,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATAWIDTH-1:0]  rd_data,
    output logic [DATAWIDTH-1:0]  din,
    output logic [MUXCONTROL-1:0] control,
    output logic [X_MAC*2-1:0]    buffermux,
    output logic [X_MAC-1:0]      iszero,
    output logic                  dout_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg
);

    localparam logic [2:0] c_FSM_IDLE  = 3'd0;
    localparam logic [2:0] c_FSM_STEP  = 3'd1;
    localparam logic [2:0] c_FSM_TAIL  = 3'd2;
    localparam logic [2:0] c_FSM_GAP   = 3'd3;
    localparam logic [2:0] c_FSM_DRAIN = 3'd4;

    logic [2:0]            r_state;
    logic                  r_pad;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_k;
    logic [LINE_W-1:0]     r_lines_left;
    logic [ADDR_W-1:0]     r_line_base;
    logic [ADDR_W-1:0]     r_stride;
    logic                  r_tail_ph;
    logic                  r_rd_en;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [MUXCONTROL-1:0] r_code;
    logic                  r_last;
    logic [X_MAC*2-1:0]    r_buffermux;
    logic [X_MAC-1:0]      r_iszero;
    logic                  r_busy;
    logic                  r_err;
    logic                  w_done;
    logic                  w_last_line;

    assign w_last_line = (r_lines_left == LINE_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_FSM_IDLE;
            r_pad        <= 1'b0;
            r_len        <= '0;
            r_k          <= '0;
            r_lines_left <= '0;
            r_line_base  <= '0;
            r_stride     <= '0;
            r_tail_ph    <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_code       <= ST_IDLE;
            r_last       <= 1'b0;
            r_buffermux  <= '0;
            r_iszero     <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err   <= 1'b0;
            r_rd_en <= 1'b0;
            r_code  <= ST_IDLE;
            r_last  <= 1'b0;
            case (r_state)
                c_FSM_IDLE: begin
                    if (start) begin
                        if (cfg_len < LEN_W'(2) || cfg_lines == '0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_pad        <= cfg_pad;
                            r_len        <= cfg_len;
                            r_lines_left <= cfg_lines;
                            r_line_base  <= cfg_base;
                            r_stride     <= cfg_stride;
                            r_buffermux  <= cfg_buffermux;
                            r_iszero     <= cfg_zero;
                            r_k          <= '0;
                            r_busy       <= 1'b1;
                            r_state      <= c_FSM_STEP;
                        end
                    end
                end
                c_FSM_STEP: begin
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= r_line_base + ADDR_W'(r_k);
                    r_code    <= step_code(r_pad, r_k == '0, r_k == LEN_W'(1), r_k[0]);
                    if (r_k == r_len - LEN_W'(1)) begin
                        r_k       <= '0;
                        r_tail_ph <= 1'b0;
                        r_last    <= !r_pad && w_last_line;
                        r_state   <= r_pad ? c_FSM_TAIL : c_FSM_GAP;
                    end else begin
                        r_k <= r_k + LEN_W'(1);
                    end
                end
                c_FSM_TAIL: begin
                    r_tail_ph <= 1'b1;
                    r_code    <= r_tail_ph ? ST_PAD_END_4 : ST_PAD_END_3;
                    if (r_tail_ph) begin
                        r_last  <= w_last_line;
                        r_state <= c_FSM_GAP;
                    end
                end
                c_FSM_GAP: begin
                    r_line_base  <= r_line_base + r_stride;
                    r_lines_left <= r_lines_left - LINE_W'(1);
                    r_state      <= w_last_line ? c_FSM_DRAIN : c_FSM_STEP;
                end
                c_FSM_DRAIN: begin
                    // w_done is the tag riding with the final code, so it fires the
                    // same cycle that code reaches control.
                    if (w_done) begin
                        r_busy  <= 1'b0;
                        r_state <= c_FSM_IDLE;
                    end
                end
                default: r_state <= c_FSM_IDLE;
            endcase
        end
    end

    seq_delay_pipe #(
        .DEPTH   (RD_LAT),
        .WIDTH   (MUXCONTROL + 1),
        .RST_VAL ({1'b0, ST_IDLE})
    ) u_ctrl_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({r_last, r_code}),
        .dout  ({w_done, control})
    );

    seq_delay_pipe #(
        .DEPTH   (DOUT_LAT),
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_valid_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (control != ST_IDLE),
        .dout  (dout_valid)
    );

    assign din       = rd_data;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign buffermux = r_buffermux;
    assign iszero    = r_iszero;
    assign busy      = r_busy;
    assign done      = w_done;
    assign err_cfg   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_buffer_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_shift_sequencer
// Description : Self-checking bench for buffer_shift_sequencer.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_buffer_shift_sequencer;

    localparam int RD_LAT   = 2;
    localparam int DOUT_LAT = 3;
    localparam int DW       = 4 * 16 * 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cfg_pad = 1'b0;
    logic [7:0]    cfg_len = '0;
    logic [7:0]    cfg_lines = '0;
    logic [9:0]    cfg_base = '0;
    logic [9:0]    cfg_stride = '0;
    logic [7:0]    cfg_buffermux = '0;
    logic [3:0]    cfg_zero = '0;
    logic          rd_en;
    logic [9:0]    rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] din;
    logic [3:0]    control;
    logic [7:0]    buffermux;
    logic [3:0]    iszero;
    logic          dout_valid;
    logic          busy;
    logic          done;
    logic          err_cfg;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    buffer_shift_sequencer #(
        .RD_LAT   (RD_LAT),
        .DOUT_LAT (DOUT_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_pad       (cfg_pad),
        .cfg_len       (cfg_len),
        .cfg_lines     (cfg_lines),
        .cfg_base      (cfg_base),
        .cfg_stride    (cfg_stride),
        .cfg_buffermux (cfg_buffermux),
        .cfg_zero      (cfg_zero),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .din           (din),
        .control       (control),
        .buffermux     (buffermux),
        .iszero        (iszero),
        .dout_valid    (dout_valid),
        .busy          (busy),
        .done          (done),
        .err_cfg       (err_cfg)
    );

    task automatic randomize_rd_data();
        for (int i = 0; i < DW / 32; i++)
            rd_data[i*32 +: 32] = $urandom();
    endtask

    // Expected code for word k of a line, straight from the code table.
    function automatic int exp_step(input bit pad, input int k);
        int off;
        if (k == 0)          off = 0;
        else if (k == 1)     off = 1;
        else if (k % 2 == 0) off = 2;
        else                 off = 3;
        return (pad ? 0 : 4) + off;
    endfunction

    // Runs one command from an idle DUT; the model is a per-cycle timeline of
    // issued reads/codes, from which control, dout_valid, done and busy follow.
    task automatic run_cmd(input bit pad, input int len, input int lines,
                           input int base, input int stride,
                           input logic [7:0] bm, input logic [3:0] z,
                           input bit disturb);
        int  iss_code [256];
        bit  iss_en   [256];
        int  iss_addr [256];
        int  t, bl, last_t, done_c, end_c, ctl, dvc;
        bit  dv;
        for (int i = 0; i < 256; i++) begin
            iss_code[i] = 15; iss_en[i] = 1'b0; iss_addr[i] = 0;
        end
        t = 1; bl = base; last_t = 1;
        for (int l = 0; l < lines; l++) begin
            for (int k = 0; k < len; k++) begin
                iss_en[t] = 1'b1;
                iss_addr[t] = (bl + k) % 1024;
                iss_code[t] = exp_step(pad, k);
                last_t = t;
                t++;
            end
            if (pad) begin
                iss_code[t] = 8; t++;
                iss_code[t] = 9; last_t = t; t++;
            end
            t++;
            bl = (bl + stride) % 1024;
        end
        done_c = last_t + RD_LAT;
        end_c  = done_c + DOUT_LAT + 2;

        @(negedge clk);
        start = 1'b1; cfg_pad = pad; cfg_len = 8'(len); cfg_lines = 8'(lines);
        cfg_base = 10'(base); cfg_stride = 10'(stride);
        cfg_buffermux = bm; cfg_zero = z;
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c <= end_c; c++) begin
            ctl = (c - RD_LAT >= 1) ? iss_code[c - RD_LAT] : 15;
            dvc = c - DOUT_LAT - RD_LAT;
            dv  = (dvc >= 1) ? (iss_code[dvc] != 15) : 1'b0;
            checks++;
            if (rd_en !== iss_en[c]) begin
                failures++;
                $display("FAIL rd_en cycle %0d: got %b expected %b", c, rd_en, iss_en[c]);
            end
            if (iss_en[c]) begin
                checks++;
                if (rd_addr !== 10'(iss_addr[c])) begin
                    failures++;
                    $display("FAIL rd_addr cycle %0d: got %0h expected %0h", c, rd_addr, iss_addr[c]);
                end
            end
            checks++;
            if (control !== 4'(ctl)) begin
                failures++;
                $display("FAIL control cycle %0d: got %0d expected %0d", c, control, ctl);
            end
            checks++;
            if (dout_valid !== dv) begin
                failures++;
                $display("FAIL dout_valid cycle %0d: got %b expected %b", c, dout_valid, dv);
            end
            checks++;
            if (done !== (c == done_c)) begin
                failures++;
                $display("FAIL done cycle %0d: got %b expected %b", c, done, (c == done_c));
            end
            checks++;
            if (busy !== (c <= done_c)) begin
                failures++;
                $display("FAIL busy cycle %0d: got %b expected %b", c, busy, (c <= done_c));
            end
            checks++;
            if (err_cfg !== 1'b0) begin
                failures++;
                $display("FAIL err_cfg cycle %0d: got %b expected 0", c, err_cfg);
            end
            checks++;
            if (buffermux !== bm || iszero !== z) begin
                failures++;
                $display("FAIL latched_cfg cycle %0d: got %h/%b expected %h/%b", c, buffermux, iszero, bm, z);
            end
            checks++;
            if (din !== rd_data) begin
                failures++;
                $display("FAIL din_passthrough cycle %0d: got %h expected %h", c, din[31:0], rd_data[31:0]);
            end
            // Everything driven while busy must be ignored.
            start = disturb && (c == 2);
            cfg_pad = $urandom_range(0, 1);
            cfg_len = 8'($urandom_range(0, 9));
            cfg_lines = 8'($urandom_range(0, 3));
            cfg_base = 10'($urandom());
            cfg_stride = 10'($urandom());
            cfg_buffermux = ~bm;
            cfg_zero = ~z;
            randomize_rd_data();
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (control !== 4'd15 || rd_en !== 1'b0 || rd_addr !== 10'd0 || buffermux !== 8'd0 ||
            iszero !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || err_cfg !== 1'b0 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: got ctl=%0d en=%b addr=%0h bm=%h z=%b busy=%b done=%b err=%b dv=%b expected 15/0/0/0/0/0/0/0/0",
                     control, rd_en, rd_addr, buffermux, iszero, busy, done, err_cfg, dout_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed();
        run_cmd(1'b0, 4, 1, 'h10, 0, 8'hA5, 4'b1001, 1'b0);
        run_cmd(1'b1, 3, 1, 'h20, 0, 8'h3C, 4'b0001, 1'b0);
        run_cmd(1'b1, 4, 1, 'h3FE, 0, 8'h11, 4'b0100, 1'b0);
        run_cmd(1'b0, 4, 2, 0, 8, 8'h77, 4'b1111, 1'b0);
        run_cmd(1'b0, 2, 1, 'h3FF, 0, 8'h01, 4'b0000, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_cmd(1'b0, 5, 2, 'h40, 'h10, 8'hE4, 4'b0010, 1'b1);
        run_cmd(1'b1, 4, 2, 'h100, 'h3F0, 8'hE4, 4'b0010, 1'b1);
    endtask

    task automatic test_err_cfg(input int len, input int lines);
        @(negedge clk);
        start = 1'b1; cfg_len = 8'(len); cfg_lines = 8'(lines);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err_cfg !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse len=%0d lines=%0d: got err=%b busy=%b expected 1/0", len, lines, err_cfg, busy);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (err_cfg !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0 || control !== 4'd15) begin
                failures++;
                $display("FAIL err_quiet len=%0d lines=%0d: got err=%b busy=%b en=%b done=%b ctl=%0d expected 0/0/0/0/15",
                         len, lines, err_cfg, busy, rd_en, done, control);
            end
        end
    endtask

    task automatic test_reset_mid_command();
        @(negedge clk);
        start = 1'b1; cfg_pad = 1'b0; cfg_len = 8'd4; cfg_lines = 8'd1;
        cfg_base = 10'h10; cfg_stride = 10'd0; cfg_buffermux = 8'hE4; cfg_zero = 4'b0010;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || control === 4'd15) begin
            failures++;
            $display("FAIL pre_reset_active: got busy=%b ctl=%0d expected busy=1 ctl!=15", busy, control);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (control !== 4'd15 || rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || buffermux !== 8'd0) begin
            failures++;
            $display("FAIL async_reset: got ctl=%0d en=%b busy=%b done=%b bm=%h expected 15/0/0/0/00",
                     control, rd_en, busy, done, buffermux);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_quiet: got done=%b busy=%b dv=%b expected 0/0/0", done, busy, dout_valid);
            end
        end
        run_cmd(1'b0, 4, 1, 'h10, 0, 8'hE4, 4'b0010, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_cmd($urandom_range(0, 1), $urandom_range(2, 7), $urandom_range(1, 3),
                    $urandom_range(0, 1023), $urandom_range(0, 1023),
                    8'($urandom()), 4'($urandom()), $urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        randomize_rd_data();
        test_reset();
        test_directed();
        test_err_cfg(1, 1);
        test_err_cfg(0, 2);
        test_err_cfg(4, 0);
        test_start_while_busy();
        test_reset_mid_command();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/buffer_shift_sequencer.md
Name: buffer_shift_sequencer

Overview:
Upstream control stage for the buffer shift register. It reads one DATAWIDTH word per step from the line buffer RAM and generates the per-cycle control code sequence (padded or unpadded line), buffermux and iszero. Control outputs are delayed to line up with the RAM read data. It passes read data straight through to the shift register's din. A start/busy/done handshake with the layer controller covers one or more lines per command.

Parameters:
X_MAC, 4, MAC columns per mesh row
X_MESH, 16, mesh rows
DATA_LEN, 32, bits per lane
MUXCONTROL, 4, control code width
DATAWIDTH, X_MAC*X_MESH*DATA_LEN, RAM word / din width
ADDR_W, 10, buffer RAM address width
LEN_W, 8, words-per-line counter width
LINE_W, 8, line counter width
RD_LAT, 2, RAM read latency in cycles (>=1)
DOUT_LAT, 3, shift-register control-to-dout latency

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command pulse; sampled only when busy=0
cfg_pad  in  1  1 = padded line sequence, 0 = unpadded
cfg_len  in  LEN_W  words per line (N), legal N>=2
cfg_lines  in  LINE_W  lines per command, legal >=1
cfg_base  in  ADDR_W  address of the first word of line 0
cfg_stride  in  ADDR_W  address increment between line starts
cfg_buffermux  in  X_MAC*2  column select, latched at start
cfg_zero  in  X_MAC  zero mask, latched at start
rd_en  out  1  RAM read strobe
rd_addr  out  ADDR_W  RAM read address
rd_data  in  DATAWIDTH  RAM data, valid RD_LAT cycles after rd_en
din  out  DATAWIDTH  equals rd_data (combinational passthrough)
control  out  MUXCONTROL  step code to shift register
buffermux  out  X_MAC*2  latched cfg_buffermux
iszero  out  X_MAC  latched cfg_zero
dout_valid  out  1  marks a shift-register dout cycle carrying a step result
busy  out  1  command in progress
done  out  1  one-cycle pulse at end of command
err_cfg  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Codes: PAD_INIT_1=0, PAD_INIT_2=1, PAD_UINIT_1=2, PAD_UINIT_2=3, UPAD_INIT_1=4, UPAD_INIT_2=5, UPAD_UINIT_1=6, UPAD_UINIT_2=7, PAD_END_3=8, PAD_END_4=9, IDLE=15. IDLE clears the downstream register.
- Reset values: control=15, rd_en=0, rd_addr=0, buffermux=0, iszero=0, busy=0, done=0, err_cfg=0, dout_valid=0. The delay pipe is filled with IDLE/invalid.
- FSM states are IDLE, STEP, TAIL, GAP, DRAIN.
- IDLE: on start with cfg_len<2 or cfg_lines=0, pulse err_cfg next cycle and stay in IDLE. On a legal start, latch all cfg_*, set busy, and go to STEP.
- STEP, for k = 0..N-1: issue rd_en=1 with rd_addr = line_base+k. The step code is INIT_1 when k=0, INIT_2 when k=1, UINIT_1 when k is even and >=2, UINIT_2 when k is odd and >=3. PAD_* codes are used if pad=1, UPAD_* otherwise.
- After k=N-1: go to TAIL if pad=1, else GAP. TAIL issues PAD_END_3 then PAD_END_4, with rd_en=0.
- GAP lasts one cycle with code IDLE and rd_en=0, and line_base += cfg_stride (modulo 2^ADDR_W). If lines remain, go to STEP; otherwise go to DRAIN.
- The step code enters a RD_LAT-deep delay pipe, so control equals the code issued RD_LAT cycles earlier, aligned with rd_data/din.
- Latency: start sampled at edge 0 -> first rd_en at cycle 1 -> first control at cycle 1+RD_LAT.
- dout_valid: a non-IDLE code on control is echoed DOUT_LAT cycles later.
- DRAIN: wait until the last non-IDLE code has appeared on control, pulse done in that same cycle, then clear busy next cycle and return to IDLE.
- start while busy=1 is ignored; no err_cfg is raised. cfg changes during busy have no effect.
- An asynchronous reset mid-command immediately forces all reset values; no done is issued and in-flight pipe entries are discarded.

Decomposition:
- Shared package holds the code constants (ST_*, ST_IDLE=15) and MUXCONTROL, common with the shift register so both use one definition.
- One sub-module, seq_delay_pipe: a parameterised DEPTH x WIDTH shift pipe with async reset value. It is instantiated for control (depth RD_LAT, reset 15) and dout_valid (depth DOUT_LAT, reset 0).

Test Plan:
- RD_LAT=2, pad=0, len=4, lines=1, base=0x10: rd_addr 0x10..0x13 at cycles 1-4; control 4,5,6,7 at cycles 3-6; done at cycle 6; dout_valid cycles 6-9.
- pad=1, len=3 -> control 0,1,2,8,9 with rd_en only 3 cycles. pad=1, len=4 -> control 0,1,2,3,8,9.
- pad=0, len=4, lines=2, base=0, stride=8: addresses 0-3 then 8-11; control shows 15 for exactly one cycle between lines; a single done.
- cfg_len=1 or cfg_lines=0 -> err_cfg one pulse; busy, rd_en and done stay 0; control stays 15.
- Drop rst_n during step 2 -> same cycle control=15, rd_en=0, busy=0. A fresh start after release runs the full sequence correctly.
- start during busy with different cfg_buffermux -> ignored; buffermux/iszero hold the first latched values (e.g. 8'hE4, 4'b0010) until done.
